// File: rtl/frontend_tx_ip_hdr_assembler_if.sv
// ============================================================================
// Module  : frontend_tx_ip_hdr_assembler_if
// Brief   : Header/segment handshake bundle for the TX IPv4 header assembler.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

interface frontend_tx_ip_hdr_assembler_if;
  logic                         src_ip_tx_hdr_val;
  logic                         ip_src_tx_hdr_rdy;
  logic [`IP_ADDR_W-1:0]        src_ip_tx_src_ip;
  logic [`IP_ADDR_W-1:0]        src_ip_tx_dst_ip;
  logic [`TOT_LEN_W-1:0]        src_ip_tx_tcp_len;
  logic                         src_ip_tx_data_val;
  logic                         ip_src_tx_data_rdy;
  logic [`MAC_INTERFACE_W-1:0]  src_ip_tx_data;
  logic                         src_ip_tx_data_last;
  logic [`MAC_PADBYTES_W-1:0]   src_ip_tx_data_padbytes;
  logic                         ip_dst_tx_hdr_val;
  logic                         dst_ip_tx_hdr_rdy;
  logic [159:0]                 ip_dst_tx_ip_hdr;
  logic                         ip_dst_tx_data_val;
  logic                         dst_ip_tx_data_rdy;
  logic [`MAC_INTERFACE_W-1:0]  ip_dst_tx_data;
  logic                         ip_dst_tx_data_last;
  logic [`MAC_PADBYTES_W-1:0]   ip_dst_tx_data_padbytes;

  // Assembler's view of the bundle.
  modport slave (
    input  src_ip_tx_hdr_val, src_ip_tx_src_ip, src_ip_tx_dst_ip, src_ip_tx_tcp_len,
    input  src_ip_tx_data_val, src_ip_tx_data, src_ip_tx_data_last, src_ip_tx_data_padbytes,
    input  dst_ip_tx_hdr_rdy, dst_ip_tx_data_rdy,
    output ip_src_tx_hdr_rdy, ip_src_tx_data_rdy,
    output ip_dst_tx_hdr_val, ip_dst_tx_ip_hdr,
    output ip_dst_tx_data_val, ip_dst_tx_data, ip_dst_tx_data_last, ip_dst_tx_data_padbytes
  );

  // Surrounding pipeline's view (upstream source plus downstream sink).
  modport master (
    output src_ip_tx_hdr_val, src_ip_tx_src_ip, src_ip_tx_dst_ip, src_ip_tx_tcp_len,
    output src_ip_tx_data_val, src_ip_tx_data, src_ip_tx_data_last, src_ip_tx_data_padbytes,
    output dst_ip_tx_hdr_rdy, dst_ip_tx_data_rdy,
    input  ip_src_tx_hdr_rdy, ip_src_tx_data_rdy,
    input  ip_dst_tx_hdr_val, ip_dst_tx_ip_hdr,
    input  ip_dst_tx_data_val, ip_dst_tx_data, ip_dst_tx_data_last, ip_dst_tx_data_padbytes
  );
endinterface

`default_nettype wire

// File: rtl/frontend_tx_ip_hdr_assembler.sv
// ============================================================================
// Module  : frontend_tx_ip_hdr_assembler
// Brief   : Builds the 20-byte IPv4 header for one TCP segment, then forwards
//           the segment. Checksum generation enabled by FRONTEND_TX_IP_HDR_CHKSUM_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module frontend_tx_ip_hdr_assembler #(
  parameter logic [7:0]  TTL_VAL   = 8'd64,
  parameter logic [7:0]  PROTO_VAL = 8'd6,
  parameter logic [15:0] ID_INIT   = 16'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  frontend_tx_ip_hdr_assembler_if.slave  bus,
  output logic                           ip_tx_len_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    FOLD = 3'd2,
    HDR  = 3'd3,
    DATA = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_hdr_rdy;
  logic          w_hdr_val;
  logic          w_data_val;
  logic          w_data_rdy;
  logic [159:0]  r_hdr;
  logic [15:0]   r_id;
  logic          r_len_err;
  logic [15:0]   w_total_len;
  logic          w_hdr_accept;

  assign w_total_len  = bus.src_ip_tx_tcp_len[15:0] + 16'd20;
  assign w_hdr_accept = (r_state == IDLE) && bus.src_ip_tx_hdr_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_hdr_rdy  = 1'b0;
    w_hdr_val  = 1'b0;
    w_data_val = 1'b0;
    w_data_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        w_hdr_rdy = 1'b1;
        if (bus.src_ip_tx_hdr_val) begin
`ifdef FRONTEND_TX_IP_HDR_CHKSUM_EN
          w_next = SUM;
`else
          w_next = HDR;
`endif
        end
      end
      SUM:  w_next = FOLD;
      FOLD: w_next = HDR;
      HDR: begin
        w_hdr_val = 1'b1;
        if (bus.dst_ip_tx_hdr_rdy) begin
          w_next = DATA;
        end
      end
      DATA: begin
        w_data_val = bus.src_ip_tx_data_val;
        w_data_rdy = bus.dst_ip_tx_data_rdy;
        if (bus.src_ip_tx_data_val && bus.dst_ip_tx_data_rdy && bus.src_ip_tx_data_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef FRONTEND_TX_IP_HDR_CHKSUM_EN
  logic [19:0] r_sum;
  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  // Checksum word (bytes 10-11) is still zero while SUM runs.
  always_comb begin
    w_sum = 20'd0;
    for (int i = 0; i < 10; i++) begin
      w_sum = w_sum + {4'd0, r_hdr[159 - 16*i -: 16]};
    end
  end

  assign w_fold1 = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= 20'd0;
    end else if (r_state == SUM) begin
      r_sum <= w_sum;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr     <= 160'd0;
      r_id      <= ID_INIT;
      r_len_err <= 1'b0;
    end else begin
      if (w_hdr_accept) begin
        r_hdr <= {8'h45, 8'h00, w_total_len, r_id, 16'h4000, TTL_VAL, PROTO_VAL,
                  16'h0000, bus.src_ip_tx_src_ip, bus.src_ip_tx_dst_ip};
        if (bus.src_ip_tx_tcp_len > 16'd65515) begin
          r_len_err <= 1'b1;
        end
      end
`ifdef FRONTEND_TX_IP_HDR_CHKSUM_EN
      if (r_state == FOLD) begin
        r_hdr[79:64] <= ~w_fold2;
      end
`endif
      if ((r_state == HDR) && bus.dst_ip_tx_hdr_rdy) begin
        r_id <= r_id + 16'd1;
      end
    end
  end

  assign bus.ip_src_tx_hdr_rdy       = w_hdr_rdy;
  assign bus.ip_dst_tx_hdr_val       = w_hdr_val;
  assign bus.ip_dst_tx_ip_hdr        = r_hdr;
  assign bus.ip_dst_tx_data_val      = w_data_val;
  assign bus.ip_src_tx_data_rdy      = w_data_rdy;
  assign bus.ip_dst_tx_data          = bus.src_ip_tx_data;
  assign bus.ip_dst_tx_data_last     = bus.src_ip_tx_data_last;
  assign bus.ip_dst_tx_data_padbytes = bus.src_ip_tx_data_padbytes;
  assign ip_tx_len_err               = r_len_err;

endmodule

`default_nettype wire
